// File: rtl/pe_result_drain.sv
// Snapshots an N x N PE array's accumulators on a capture pulse and streams them row-major
// over valid/ready. Optional build macro PE_DRAIN_SAT_EN clamps each value to SAT_W bits.
module pe_result_drain #(
  parameter int N       = 4,
  parameter int Y_WIDTH = 32,
  parameter int SAT_W   = 16
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_capture,
  input  logic [N*N*Y_WIDTH-1:0]    i_y,
  output logic                      o_valid,
  input  logic                      i_ready,
  output logic [Y_WIDTH-1:0]        o_data,
  output logic [($clog2(N)|1)-1:0]  o_row,
  output logic [($clog2(N)|1)-1:0]  o_col,
  output logic                      o_last,
  output logic                      o_busy,
  output logic                      o_done,
  output logic                      o_overrun
);

  localparam int TOTAL = N * N;
  localparam int IDX_W = (TOTAL > 1) ? $clog2(TOTAL) : 1;
  localparam int RC_W  = $clog2(N) | 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TOTAL - 1);

  // Valid/ready: o_valid is high for the whole DRAIN state; a beat transfers on any
  // cycle with o_valid & i_ready, and o_data/o_row/o_col/o_last hold while it does not.

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  state_t               state, state_nxt;
  logic [IDX_W-1:0]     idx;
  logic [Y_WIDTH-1:0]   snap [TOTAL];
  logic                 load;
  logic                 overrun_set;
  logic                 hs;
  logic                 final_hs;

`ifdef PE_DRAIN_SAT_EN
  localparam logic [Y_WIDTH-1:0] SAT_MAX = (Y_WIDTH'(1) << (SAT_W - 1)) - Y_WIDTH'(1);
  localparam logic [Y_WIDTH-1:0] SAT_MIN = ~SAT_MAX;

  // Clamp at capture time so the output path remains a plain mux.
  function automatic logic [Y_WIDTH-1:0] shape(input logic [Y_WIDTH-1:0] v);
    if ($signed(v) > $signed(SAT_MAX))      return SAT_MAX;
    else if ($signed(v) < $signed(SAT_MIN)) return SAT_MIN;
    else                                    return v;
  endfunction
`else
  function automatic logic [Y_WIDTH-1:0] shape(input logic [Y_WIDTH-1:0] v);
    return v;
  endfunction
`endif

  assign hs       = o_valid & i_ready;
  assign final_hs = hs & (idx == LAST_IDX);

  always_comb begin
    state_nxt   = state;
    load        = 1'b0;
    overrun_set = 1'b0;
    case (state)
      IDLE: begin
        if (i_capture) begin
          state_nxt = DRAIN;
          load      = 1'b1;
        end
      end
      DRAIN: begin
        if (final_hs) begin
          // A capture coinciding with the last beat chains straight into the next job.
          if (i_capture) load = 1'b1;
          else           state_nxt = IDLE;
        end else if (i_capture) begin
          overrun_set = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state     <= IDLE;
      idx       <= '0;
      o_done    <= 1'b0;
      o_overrun <= 1'b0;
      for (int k = 0; k < TOTAL; k++) snap[k] <= '0;
    end else begin
      state  <= state_nxt;
      o_done <= final_hs;
      if (overrun_set) o_overrun <= 1'b1;
      if (load) begin
        idx <= '0;
        for (int k = 0; k < TOTAL; k++) snap[k] <= shape(i_y[k*Y_WIDTH +: Y_WIDTH]);
      end else if (final_hs) begin
        idx <= '0;
      end else if (hs) begin
        idx <= idx + 1'b1;
      end
    end
  end

  assign o_valid = (state == DRAIN);
  assign o_busy  = (state == DRAIN);
  assign o_data  = snap[idx];
  assign o_row   = RC_W'(idx / N);
  assign o_col   = RC_W'(idx % N);
  assign o_last  = o_valid & (idx == LAST_IDX);

endmodule

// File: tb/tb_pe_result_drain.sv
// Directed bench for pe_result_drain with N=2, Y_WIDTH=32; define PE_DRAIN_SAT_EN to
// also run the saturation scenario.
module tb_pe_result_drain;

  localparam int N = 2;
  localparam int W = 32;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           capture;
  logic [N*N*W-1:0] y;
  logic           valid;
  logic           ready;
  logic [W-1:0]   data;
  logic           row;
  logic           col;
  logic           last;
  logic           busy;
  logic           done;
  logic           overrun;

  int n_checks = 0;
  int n_fail   = 0;

  logic [W-1:0] exp_a [4];
  logic [W-1:0] exp_b [4];

  pe_result_drain #(.N(N), .Y_WIDTH(W), .SAT_W(16)) dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_capture (capture),
    .i_y       (y),
    .o_valid   (valid),
    .i_ready   (ready),
    .o_data    (data),
    .o_row     (row),
    .o_col     (col),
    .o_last    (last),
    .o_busy    (busy),
    .o_done    (done),
    .o_overrun (overrun)
  );

  always #5 clk = ~clk;

  function automatic logic [N*N*W-1:0] pack_y(input logic [W-1:0] e0, e1, e2, e3);
    return {e3, e2, e1, e0};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; capture = 1'b0; ready = 1'b0; y = '0;
    tick(); tick();
    n_checks++;
    if ({valid, busy, done, overrun, last} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got %b expected 00000", {valid, busy, done, overrun, last});
    end
    n_checks++;
    if ({data, row, col} !== '0) begin
      n_fail++;
      $display("FAIL reset_data: got %0h/%0d/%0d expected 0/0/0", data, row, col);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_stream();
    y = pack_y(1, 2, -3, 4); capture = 1'b1; ready = 1'b1;
    tick();
    capture = 1'b0;
    for (int b = 0; b < 4; b++) begin
      n_checks++;
      if (valid !== 1'b1 || data !== exp_a[b] || row !== 1'(b / 2) || col !== 1'(b % 2)
          || last !== (b == 3) || done !== 1'b0) begin
        n_fail++;
        $display("FAIL stream_beat%0d: got v=%b d=%0d r=%0d c=%0d l=%b dn=%b expected v=1 d=%0d r=%0d c=%0d l=%b dn=0",
                 b, valid, $signed(data), row, col, last, done, $signed(exp_a[b]), b / 2, b % 2, b == 3);
      end
      tick();
    end
    n_checks++;
    if (done !== 1'b1 || valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL stream_done: got dn=%b v=%b bz=%b expected 1 0 0", done, valid, busy);
    end
    tick();
    n_checks++;
    if (done !== 1'b0) begin
      n_fail++;
      $display("FAIL stream_done_pulse: got %b expected 0", done);
    end
  endtask

  task automatic test_ready_toggle();
    logic rdy_pat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    int b;
    int cyc;
    y = pack_y(1, 2, -3, 4); capture = 1'b1; ready = 1'b0;
    tick();
    capture = 1'b0;
    b = 0; cyc = 0;
    while (b < 4 && cyc < 20) begin
      ready = (cyc < 7) ? rdy_pat[cyc] : 1'b1;
      n_checks++;
      if (valid !== 1'b1 || data !== exp_a[b] || row !== 1'(b / 2) || col !== 1'(b % 2)) begin
        n_fail++;
        $display("FAIL toggle_cyc%0d: got v=%b d=%0d r=%0d c=%0d expected v=1 d=%0d r=%0d c=%0d",
                 cyc, valid, $signed(data), row, col, $signed(exp_a[b]), b / 2, b % 2);
      end
      if (ready) b++;
      cyc++;
      tick();
    end
    ready = 1'b1;
    n_checks++;
    if (b !== 4 || cyc !== 7) begin
      n_fail++;
      $display("FAIL toggle_count: got beats=%0d cycles=%0d expected 4 7", b, cyc);
    end
    n_checks++;
    if (done !== 1'b1 || valid !== 1'b0) begin
      n_fail++;
      $display("FAIL toggle_done: got dn=%b v=%b expected 1 0", done, valid);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    y = pack_y(1, 2, -3, 4); capture = 1'b1; ready = 1'b1;
    tick();
    capture = 1'b0;
    for (int b = 0; b < 3; b++) tick();
    n_checks++;
    if (last !== 1'b1 || data !== exp_a[3]) begin
      n_fail++;
      $display("FAIL b2b_first_last: got l=%b d=%0d expected 1 4", last, $signed(data));
    end
    y = pack_y(5, 6, 7, 8); capture = 1'b1;
    tick();
    capture = 1'b0;
    n_checks++;
    if (done !== 1'b1 || valid !== 1'b1 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_chain: got dn=%b v=%b bz=%b expected 1 1 1", done, valid, busy);
    end
    for (int b = 0; b < 4; b++) begin
      n_checks++;
      if (valid !== 1'b1 || data !== exp_b[b] || row !== 1'(b / 2) || col !== 1'(b % 2)
          || last !== (b == 3)) begin
        n_fail++;
        $display("FAIL b2b_beat%0d: got v=%b d=%0d r=%0d c=%0d l=%b expected v=1 d=%0d r=%0d c=%0d l=%b",
                 b, valid, $signed(data), row, col, last, $signed(exp_b[b]), b / 2, b % 2, b == 3);
      end
      tick();
    end
    n_checks++;
    if (done !== 1'b1 || valid !== 1'b0 || overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_end: got dn=%b v=%b ov=%b expected 1 0 0", done, valid, overrun);
    end
    tick();
  endtask

  task automatic test_overrun();
    y = pack_y(1, 2, -3, 4); capture = 1'b1; ready = 1'b1;
    tick();
    capture = 1'b0;
    tick(); tick();
    n_checks++;
    if (data !== exp_a[2] || overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL ovr_beat2: got d=%0d ov=%b expected -3 0", $signed(data), overrun);
    end
    y = pack_y(5, 6, 7, 8); capture = 1'b1;
    tick();
    capture = 1'b0;
    n_checks++;
    if (data !== exp_a[3] || last !== 1'b1 || overrun !== 1'b1) begin
      n_fail++;
      $display("FAIL ovr_beat3: got d=%0d l=%b ov=%b expected 4 1 1", $signed(data), last, overrun);
    end
    tick();
    n_checks++;
    if (done !== 1'b1 || valid !== 1'b0 || overrun !== 1'b1) begin
      n_fail++;
      $display("FAIL ovr_end: got dn=%b v=%b ov=%b expected 1 0 1", done, valid, overrun);
    end
    tick(); tick();
    n_checks++;
    if (overrun !== 1'b1) begin
      n_fail++;
      $display("FAIL ovr_sticky: got %b expected 1", overrun);
    end
  endtask

  task automatic test_reset_mid();
    y = pack_y(1, 2, -3, 4); capture = 1'b1; ready = 1'b1;
    tick();
    capture = 1'b0;
    tick();
    n_checks++;
    if (data !== exp_a[1]) begin
      n_fail++;
      $display("FAIL rstmid_beat1: got %0d expected 2", $signed(data));
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    n_checks++;
    if (valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_idle: got v=%b bz=%b dn=%b ov=%b expected 0 0 0 0", valid, busy, done, overrun);
    end
    tick();
    n_checks++;
    if (done !== 1'b0 || valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_nodone: got dn=%b v=%b expected 0 0", done, valid);
    end
    y = pack_y(5, 6, 7, 8); capture = 1'b1;
    tick();
    capture = 1'b0;
    n_checks++;
    if (valid !== 1'b1 || data !== exp_b[0] || row !== 1'b0 || col !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_restart: got v=%b d=%0d r=%0d c=%0d expected 1 5 0 0", valid, $signed(data), row, col);
    end
    for (int b = 0; b < 5; b++) tick();
  endtask

`ifdef PE_DRAIN_SAT_EN
  task automatic test_sat();
    logic [W-1:0] exp_s [4];
    exp_s[0] = -5; exp_s[1] = 32767; exp_s[2] = -32768; exp_s[3] = 32767;
    y = pack_y(-5, 32767, -70000, 70000); capture = 1'b1; ready = 1'b1;
    tick();
    capture = 1'b0;
    for (int b = 0; b < 4; b++) begin
      n_checks++;
      if (data !== exp_s[b]) begin
        n_fail++;
        $display("FAIL sat_beat%0d: got %0d expected %0d", b, $signed(data), $signed(exp_s[b]));
      end
      tick();
    end
    tick();
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish before 200000");
    $fatal(1, "timeout");
  end

  initial begin
    exp_a[0] = 1; exp_a[1] = 2; exp_a[2] = -3; exp_a[3] = 4;
    exp_b[0] = 5; exp_b[1] = 6; exp_b[2] = 7;  exp_b[3] = 8;
    test_reset();
    test_stream();
    test_ready_toggle();
    test_back_to_back();
    test_overrun();
    test_reset_mid();
`ifdef PE_DRAIN_SAT_EN
    test_sat();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
